// File: rtl/i2c_fifo_pkg.sv
// Shared defaults and level bookkeeping for the APB/I2C bridge FIFOs.
package i2c_fifo_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 3;
  localparam int LVL_W      = 16;

  // Occupancy after one edge; push and pop together leave it unchanged.
  function automatic logic [LVL_W-1:0] level_next(
    input logic [LVL_W-1:0] lvl,
    input logic             push,
    input logic             pop
  );
    logic [LVL_W-1:0] nxt;
    nxt = lvl;
    case ({push, pop})
      2'b10:   nxt = lvl + 1'b1;
      2'b01:   nxt = lvl - 1'b1;
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// Dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// FWFT FIFO between the APB bridge and the I2C core; head word is combinational.
module i2c_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int AFULL_LVL = 6
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0] AFULL_L = (AWIDTH+1)'(AFULL_LVL);

  logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [AWIDTH:0]   r_level;
  logic              r_ovf, r_udf;

  logic              w_push, w_pop;
  logic [DWIDTH-1:0] w_mem_rd;
  logic [LVL_W-1:0]  w_lvl_nxt;

  assign full        = (r_level == DEPTH_L);
  assign empty       = (r_level == '0);
  assign almost_full = (r_level >= AFULL_L);
  assign level       = r_level;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

  // A pop frees a slot in the same edge, so a push while full is legal with rd_en.
  assign w_push    = wr_en & (~full | rd_en);
  assign w_pop     = rd_en & ~empty;
  assign w_lvl_nxt = level_next({{(LVL_W-AWIDTH-1){1'b0}}, r_level}, w_push, w_pop);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_lvl_nxt[AWIDTH:0];
      if (wr_en & full & ~rd_en) r_ovf <= 1'b1;
      if (rd_en & empty)         r_udf <= 1'b1;
    end
  end

  fifo_mem #(
    .DW (DWIDTH),
    .AW (AWIDTH)
  ) u_mem (
    .clk   (PCLK),
    .we    (w_push & ~clr),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_mem_rd)
  );

  assign rd_data = empty ? '0 : w_mem_rd;

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed and randomized checks of i2c_fifo against a queue-based reference.
module tb_i2c_fifo;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        clr, wr_en, rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        full, empty, almost_full, overflow, underflow;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          m_ov, m_un;

  i2c_fifo #(.DWIDTH(32), .AWIDTH(3), .AFULL_LVL(6)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 PCLK = ~PCLK;

  // One clock with the given request; the reference follows the rules at the edge.
  task automatic cycle(input bit w, input logic [31:0] d, input bit r, input bit c);
    int sz;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge PCLK);
    sz = mq.size();
    if (c) begin
      mq.delete(); m_ov = 0; m_un = 0;
    end else begin
      if (w && sz == 8 && !r) m_ov = 1;
      if (r && sz == 0) m_un = 1;
      if (r && sz > 0) void'(mq.pop_front());
      if (w && (sz < 8 || r)) mq.push_back(d);
    end
    #1;
    wr_en = 0; rd_en = 0; clr = 0;
  endtask

  task automatic test_reset;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got %b want 10000", {empty, full, almost_full, overflow, underflow}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
  endtask

  task automatic test_basic;
    cycle(1, 32'h11, 0, 0); cycle(1, 32'h22, 0, 0); cycle(1, 32'h33, 0, 0);
    checks++; if (level !== 4'd3 || empty !== 1'b0) begin errors++; $display("FAIL basic_level got %0d/%b want 3/0", level, empty); end
    checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL basic_head got %h want 11", rd_data); end
    cycle(0, 0, 1, 0);
    checks++; if (rd_data !== 32'h22 || level !== 4'd2) begin errors++; $display("FAIL basic_pop got %h/%0d want 22/2", rd_data, level); end
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drain empty got %b want 1", empty); end
  endtask

  task automatic test_full_overflow;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 32'hA0 + i, 0, 0);
      checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL afull_lvl%0d got %b want %b", i + 1, almost_full, (i + 1 >= 6)); end
    end
    checks++; if (full !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL full got %b/%0d want 1/8", full, level); end
    cycle(1, 32'hFF, 0, 0);
    checks++; if (overflow !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL overflow got %b/%0d want 1/8", overflow, level); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 32'hA0 + i) begin errors++; $display("FAIL drain%0d got %h want %h", i, rd_data, 32'hA0 + i); end
      cycle(0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1 || rd_data !== 32'h0) begin errors++; $display("FAIL drained got %b/%h want 1/0", empty, rd_data); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp[$];
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin d = $urandom; exp.push_back(d); cycle(1, d, 0, 0); end
    for (int i = 0; i < 20; i++) begin
      d = $urandom; exp.push_back(d);
      checks++; if (rd_data !== exp[0]) begin errors++; $display("FAIL wrap_order%0d got %h want %h", i, rd_data, exp[0]); end
      void'(exp.pop_front());
      cycle(1, d, 1, 0);
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL wrap_level%0d got %0d want 3", i, level); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp[0]) begin errors++; $display("FAIL wrap_tail%0d got %h want %h", i, rd_data, exp[0]); end
      void'(exp.pop_front());
      cycle(0, 0, 1, 0);
    end
  endtask

  task automatic test_simul;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 32'hB0 + i, 0, 0);
    cycle(1, 32'h55, 1, 0);
    checks++; if (level !== 4'd8 || overflow !== 1'b0 || rd_data !== 32'hB1) begin
      errors++; $display("FAIL full_rw got %0d/%b/%h want 8/0/b1", level, overflow, rd_data); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL full_rw_seq%0d got %h want %h", i, rd_data, mq[0]); end
      cycle(0, 0, 1, 0);
    end
    checks++; if (mq[$] !== 32'h55 && mq.size() != 0) begin errors++; $display("FAIL model_sanity"); end
    cycle(1, 32'h66, 1, 0);
    checks++; if (underflow !== 1'b1 || level !== 4'd1 || rd_data !== 32'h66) begin
      errors++; $display("FAIL empty_rw got %b/%0d/%h want 1/1/66", underflow, level, rd_data); end
  endtask

  task automatic test_clr;
    for (int i = 0; i < 7; i++) cycle(1, 32'hC0 + i, 0, 0);
    cycle(1, 32'hEE, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    checks++; if (level !== 4'd5 || overflow !== 1'b1 || underflow !== 1'b1) begin
      errors++; $display("FAIL clr_setup got %0d/%b/%b want 5/1/1", level, overflow, underflow); end
    cycle(1, 32'hDD, 0, 1);
    checks++; if (level !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL clr got %0d/%b/%b/%b/%h want 0/1/0/0/0", level, empty, overflow, underflow, rd_data); end
  endtask

  task automatic test_async_reset;
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h40 + i, 0, 0);
    @(posedge PCLK); #3;
    PRESETn = 0; mq.delete(); m_ov = 0; m_un = 0;
    #1;
    checks++; if (level !== 4'd0 || {empty, full, almost_full, overflow, underflow} !== 5'b10000 || rd_data !== 32'h0) begin
      errors++; $display("FAIL async_reset got %0d/%b/%h want 0/10000/0", level, {empty, full, almost_full, overflow, underflow}, rd_data); end
    #1; PRESETn = 1;
    cycle(1, 32'h77, 0, 0);
    checks++; if (rd_data !== 32'h77 || level !== 4'd1) begin errors++; $display("FAIL post_reset got %h/%0d want 77/1", rd_data, level); end
  endtask

  task automatic test_random;
    logic [31:0] exp_rd;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
      exp_rd = (mq.size() > 0) ? mq[0] : 32'h0;
      checks++;
      if (level !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 8) ||
          almost_full !== (mq.size() >= 6) || overflow !== m_ov || underflow !== m_un || rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rand%0d got lvl=%0d e=%b f=%b af=%b ov=%b un=%b rd=%h want lvl=%0d ov=%b un=%b rd=%h",
                 i, level, empty, full, almost_full, overflow, underflow, rd_data, mq.size(), m_ov, m_un, exp_rd);
      end
    end
  endtask

  initial begin
    PRESETn = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = 0;
    m_ov = 0; m_un = 0;
    #22;
    test_reset();
    PRESETn = 1;
    test_basic();
    test_full_overflow();
    test_wrap();
    test_simul();
    test_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous FWFT FIFO that sits directly downstream of the APB bridge's TX path (and is reused upstream of its RX path).
- Write side takes the bridge's write enable and data (TX instance) or the I2C core's received bytes (RX instance).
- Read side presents the head word combinationally so an APB read completes in its single ENABLE cycle.
- Flags drive the bridge's TX_EMPTY/RX_EMPTY interrupt inputs; sticky overflow/underflow feed its ERROR input.

Parameters:
- DWIDTH, 32, data word width.
- AWIDTH, 3, address width; depth = 2**AWIDTH (8 entries).
- AFULL_LVL, 6, level at or above which almost_full asserts; legal range 1..2**AWIDTH.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush (empties the FIFO and clears the sticky error bits).
- wr_en  in  1  push request.
- wr_data  in  DWIDTH  push data.
- rd_en  in  1  pop request.
- rd_data  out  DWIDTH  head-of-queue word (FWFT).
- full  out  1  level == 2**AWIDTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_LVL.
- level  out  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- overflow  out  1  sticky: a push was attempted while full and not simultaneously popped.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset, clock, state:
  - One clock (PCLK).
  - Reset is asynchronous and active-low (PRESETn).
  - On reset: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0.
  - Storage array is not reset.
- Pointers and level:
  - wr_ptr and rd_ptr are AWIDTH bits and wrap naturally modulo depth.
  - level is a separate AWIDTH+1-bit counter.
  - Flags are decoded combinationally from the registered level, so they are valid in the cycle after the causing edge.
- Qualified operations:
  - push = wr_en & (!full | rd_en).
  - pop = rd_en & !empty.
- Per rising edge, when not clr:
  - push only: mem[wr_ptr] <= wr_data; wr_ptr+1; level+1.
  - pop only: rd_ptr+1; level-1.
  - push & pop: both pointers advance; level unchanged. This is legal when full: the freed slot is written. When empty, the pop is not qualified, so push only applies.
  - wr_en & full & !rd_en: data dropped, no state change, overflow <= 1.
  - rd_en & empty: no state change, underflow <= 1. If wr_en is also high, the write is still accepted.
- clr:
  - Has priority over push/pop in the same cycle.
  - Pointers, level, overflow and underflow go to 0; wr_en and rd_en are ignored that cycle.
- FWFT read data:
  - rd_data = mem[rd_ptr] whenever !empty, otherwise 0.
  - Zero-latency from the pointer: a word written at edge N is visible on rd_data after edge N.
  - No same-cycle bypass from wr_data to rd_data when empty.
- Error bits:
  - overflow and underflow stay set until clr or reset.
  - They are independent; both can set in the same cycle only via separate conditions.
- Single-pop guarantee: an APB read with PREADY asserted in its ENABLE cycle holds rd_en high for exactly one cycle, so one word is consumed per transfer.
- Reset mid-operation: asynchronous assertion immediately forces all outputs to their reset values, regardless of PCLK.

Decomposition:
- Package i2c_fifo_pkg holds:
  - default DWIDTH (32) and AWIDTH (3) constants;
  - function level_next(level, push, pop).
- One sub-module, fifo_mem: simple dual-port array with a synchronous write port and an asynchronous read port, no reset. It is instantiated by i2c_fifo.
- Pointer, level, flag and error logic all stay in i2c_fifo.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles → level=3, empty=0, rd_data=0x11. Pop once → rd_data=0x22, level=2.
2. Push 8 words 0xA0..0xA7 → full=1, almost_full=1 (from level 6), level=8. A 9th push 0xFF → overflow=1, level=8. Pop 8 times → sequence 0xA0..0xA7, then empty=1, rd_data=0.
3. Wrap-around: push/pop 20 words, holding occupancy at 3 → output order equals input order across the pointer wrap; level stays 3.
4. Full with wr_en & rd_en in the same cycle, pushing 0x55 → head pops, 0x55 is stored, level stays 8, overflow stays 0. Empty with both asserted, pushing 0x66 → underflow=1, level=1, rd_data=0x66.
5. clr asserted together with wr_en at level 5 → level=0, empty=1, overflow and underflow cleared, write dropped.
6. PRESETn driven low mid-cycle at level 4 → all outputs at reset values before the next PCLK edge. After release, the first push 0x77 appears on rd_data.
